// File: rtl/dpram_req_queue.sv
// Request queue in front of one dual-port RAM port: buffers read/write requests
// in a small FIFO, issues them one at a time and returns read data in order.
module dpram_req_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  input  logic [DATA_W-1:0]          mem_q,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic              mem_valid_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  entry_t            slot_q [DEPTH];
  entry_t            head_entry;
  logic              push;
  logic              pop;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign req_ready = !rst && (count_reg < CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = mem_valid_reg && mem_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_reg;

      always_ff @(posedge clk) begin
        if (push && (tail_reg == PTR_W'(gi))) begin
          slot_reg <= '{we: req_we, addr: req_addr, data: req_data};
        end
      end

      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  assign head_entry = slot_q[head_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      mem_valid_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      count_reg     <= count_next;
      rsp_valid_reg <= 1'b0;
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg     <= ISSUE;
            mem_valid_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            if (head_entry.we) begin
              // Writes stream back-to-back while anything remains queued.
              if (count_next != '0) begin
                state_reg     <= ISSUE;
                mem_valid_reg <= 1'b1;
              end else begin
                state_reg     <= IDLE;
                mem_valid_reg <= 1'b0;
              end
            end else begin
              state_reg     <= RD_WAIT;
              mem_valid_reg <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          rsp_data_reg  <= mem_q;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RSP;
        end
        RSP: begin
          if (count_reg != '0) begin
            state_reg     <= ISSUE;
            mem_valid_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Head fields are masked while idle so uninitialised slots never show up.
  assign mem_valid = mem_valid_reg;
  assign mem_we    = mem_valid_reg & head_entry.we;
  assign mem_addr  = mem_valid_reg ? head_entry.addr : '0;
  assign mem_data  = mem_valid_reg ? head_entry.data : '0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_dpram_req_queue.sv
// Directed bench for dpram_req_queue with a one-cycle-latency RAM model.
module tb_dpram_req_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_data;
  logic       mem_valid;
  logic       mem_ready;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] mem_q;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cnt = 0;
  logic [7:0] rsp_q[$];
  int         rsp_cyc[$];
  int         rd_cyc[$];
  logic [7:0] mem_model [64];

  dpram_req_queue #(.DATA_W(8), .ADDR_W(6), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_q     (mem_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // RAM model: reset preloads addr+0x60, read data appears the cycle after the handshake.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 8'(i) + 8'h60;
      mem_q <= 8'h00;
    end else if (mem_valid && mem_ready) begin
      if (mem_we) mem_model[mem_addr] <= mem_data;
      else        mem_q <= mem_model[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (rsp_valid) begin
      rsp_q.push_back(rsp_data);
      rsp_cyc.push_back(cyc);
      $display("rsp data=0x%02h cycle=%0d", rsp_data, cyc);
    end
    if (mem_valid && mem_ready) begin
      hs_cnt++;
      if (!mem_we) rd_cyc.push_back(cyc);
      $display("mem %s addr=0x%02h data=0x%02h cycle=%0d",
               mem_we ? "wr" : "rd", mem_addr, mem_data, cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [5:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int limit);
    for (int i = 0; i < limit && rsp_q.size() < n; i++) tick();
    chk("rsp_wait", 32'(rsp_q.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    mem_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Write then read back the same address.
    mem_ready = 1'b1;
    push_req(1'b1, 6'h03, 8'hA5);
    push_req(1'b0, 6'h03, 8'h00);
    wait_rsp(1, 20);
    chk("wr_rd_data", 32'(rsp_q[0]), 32'hA5);
    chk("wr_rd_latency", 32'(rsp_cyc[0] - rd_cyc[0]), 32'd2);
    repeat (4) tick();
    chk("wr_rd_single_pulse", 32'(rsp_q.size()), 32'd1);
    chk("wr_rd_rsp_low", 32'(rsp_valid), 32'd0);

    // Fill with mem_ready low, hold a fifth request, head fields stable.
    mem_ready = 1'b0;
    b = hs_cnt;
    for (int i = 0; i < 4; i++) push_req(1'b1, 6'(8'h20 + i), 8'(8'h30 + i));
    chk("full_count", 32'(count), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h24; req_data = 8'h34;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_count", 32'(count), 32'd4);
      chk("stall_mem_valid", 32'(mem_valid), 32'd1);
      chk("stall_mem_addr", 32'(mem_addr), 32'h20);
      chk("stall_mem_data", 32'(mem_data), 32'h30);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_count", 32'(count), 32'(3 - i));
    end
    chk("drain_handshakes", 32'(hs_cnt - b), 32'd4);
    chk("drain_last_write", 32'(mem_model[6'h23]), 32'h33);

    // Three queued reads return in order, three cycles apart.
    b = rsp_q.size();
    for (int i = 0; i < 3; i++) push_req(1'b0, 6'(8'h10 + i), 8'h00);
    wait_rsp(b + 3, 40);
    for (int i = 0; i < 3; i++) chk("rd_order_data", 32'(rsp_q[b + i]), 32'(8'h70 + i));
    chk("rd_spacing_1", 32'(rsp_cyc[b + 1] - rsp_cyc[b]), 32'd3);
    chk("rd_spacing_2", 32'(rsp_cyc[b + 2] - rsp_cyc[b + 1]), 32'd3);

    // Full queue: pop frees a slot only for the following cycle.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(1'b1, 6'(8'h28 + i), 8'(8'h40 + i));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h2C; req_data = 8'h44;
    mem_ready = 1'b1;
    #1;
    chk("full_pop_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_req_ready_next", 32'(req_ready), 32'd1);
    tick();
    chk("push_pop_count", 32'(count), 32'd3);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && count != 3'd0; i++) tick();
    chk("full_drain_count", 32'(count), 32'd0);
    chk("full_drain_write", 32'(mem_model[6'h2C]), 32'h44);

    // Reset while a read waits on RAM data with two entries behind it.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_req(1'b0, 6'(8'h10 + i), 8'h00);
    mem_ready = 1'b1;
    tick();
    chk("rdwait_count", 32'(count), 32'd2);
    mem_ready = 1'b0;
    rst = 1'b1;
    b = rsp_q.size();
    tick();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("midrst_no_rsp", 32'(rsp_q.size()), 32'(b));
    chk("midrst_idle_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_idle_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_req_queue.md
DPRAM_REQ_QUEUE -- requirements
Module: dpram_req_queue

Interface
REQ-001 Parameter: DATA_W, default 8, data width of one memory word.
REQ-002 Parameter: ADDR_W, default 6, memory address width.
REQ-003 Parameter: DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-004 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: req_valid  in  1  upstream request present.
REQ-007 Port: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 Port: req_we  in  1  1=write, 0=read.
REQ-009 Port: req_addr  in  ADDR_W  request address.
REQ-010 Port: req_data  in  DATA_W  write data (ignored for reads).
REQ-011 Port: mem_valid  out  1  request driven to one dpram port.
REQ-012 Port: mem_ready  in  1  dpram port accepts request.
REQ-013 Port: mem_we, mem_addr, mem_data  out  1/ADDR_W/DATA_W  FIFO head fields.
REQ-014 Port: mem_q  in  DATA_W  dpram read data.
REQ-015 Port: rsp_valid  out  1  one-cycle pulse, read data available.
REQ-016 Port: rsp_data  out  DATA_W  read data, held until next response.
REQ-017 Port: count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 Push: req_valid&&req_ready writes {we,addr,data} at tail; req_ready = (count<DEPTH), derived from registered count only, never from pop in the same cycle.
REQ-019 No bypass: a pushed entry is visible at the FIFO head no earlier than the following cycle.
REQ-020 FSM states: IDLE, ISSUE, RD_WAIT, RSP.
REQ-021 IDLE: mem_valid=0; go to ISSUE when count!=0.
REQ-022 ISSUE: mem_valid=1, mem_* = head fields, held stable until mem_ready; on handshake pop head; if write -> ISSUE when count after pop != 0, else IDLE; if read -> RD_WAIT.
REQ-023 RD_WAIT (cycle after read handshake): mem_valid=0; capture mem_q into rsp_data; go to RSP.
REQ-024 RSP: rsp_valid=1 for exactly this cycle; mem_valid=0; go to ISSUE if count!=0 else IDLE.
REQ-025 Read latency: handshake in cycle N -> mem_q sampled at end of N+1 -> rsp_valid high in cycle N+2.
REQ-026 Writes produce no response; back-to-back writes issue one per cycle when mem_ready=1.
REQ-027 Responses are in request order; at most one read outstanding.
REQ-028 Simultaneous push and pop: count unchanged; both take effect.
REQ-029 Full (count==DEPTH): req_ready=0; request held upstream, not dropped.
REQ-030 Head/tail pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-031 mem_ready while mem_valid=0 is ignored.

Reset
REQ-032 rst=1 at posedge: state=IDLE, count=0, pointers=0, mem_valid=0, rsp_valid=0, rsp_data=0, req_ready=0 while rst=1.
REQ-033 Reset mid-operation flushes FIFO and abandons any outstanding read; no rsp_valid after reset for pre-reset requests.
REQ-034 FIFO storage need not be reset; no X may reach outputs after reset.

Verification
REQ-035 Write 0xA5 @0x03, then read @0x03, mem_ready=1, model returns q next cycle -> one rsp_valid pulse, rsp_data=0xA5, two cycles after read handshake.
REQ-036 Push 4 writes with mem_ready=0 -> count=4, req_ready=0, 5th request held; raise mem_ready -> 4 consecutive mem handshakes, count 4->0.
REQ-037 Reads @0x10,0x11,0x12 queued -> three rsp_valid pulses in order with matching data, spaced 3 cycles apart.
REQ-038 Full queue, push and pop in same cycle -> push refused (req_ready=0); next cycle count=3, req_ready=1.
REQ-039 Assert rst in RD_WAIT with 2 entries queued -> next cycle count=0, mem_valid=0, rsp_valid never pulses.
REQ-040 Hold mem_ready=0 for 5 cycles in ISSUE -> mem_addr/mem_data/mem_we stable all 5 cycles.
